uart_rx_param: RTL

Parametrised UART receiver: next generation of the team's fixed 8N1/9600-baud receiver. It oversamples the asynchronous `rxd` line with a configurable clock-per-bit divisor and mid-bit sampling, and supports 5–8 data bits and 1 or 2 stop bits. It rejects glitch starts, flags framing, overrun and (optionally) parity errors, and hands each byte to downstream logic through a valid/ready handshake. It sits between the board pin and the command/FIFO logic of the serial link.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_rx_param.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, parity-sense constants,
// the default baud divisor and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int unsigned CLKS_9600_50M = 32'd5208;

  // Expected parity bit for a zero-extended word; odd sense inverts the XOR.
  function automatic logic parity_bit(input logic [7:0] word, input bit odd);
    parity_bit = (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART receiver and transmitter: counts
// 0..CLKS_PER_BIT-1 and raises half/full ticks at the mid and last count.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 32'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic half,
  output logic full
);

  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 32'd2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 32'd1);

  logic [15:0] cnt_r;

  // Free-running bit counter, wraps at the end of each bit period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 16'd0;
    end else if (clr) begin
      cnt_r <= 16'd0;
    end else if (en) begin
      if (cnt_r == LAST_CNT) begin
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  assign half = en && (cnt_r == HALF_CNT);
  assign full = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN to expect and check a parity bit after the data bits.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_9600_50M,
  parameter int unsigned DATA_BITS    = 32'd8,
  parameter int unsigned STOP_BITS    = 32'd1,
  parameter int unsigned PARITY_ODD   = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 32'd1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 32'd1);

  uart_state_e          state_r, state_n;
  logic [1:0]           sync_r;
  logic                 rxs_s;
  logic                 tmr_clr_s, tmr_en_s, half_s, full_s;
  logic [2:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [7:0]           word_s;
  logic                 frm_flag_r, par_flag_r;
  logic [7:0]           data_r;
  logic                 valid_r, frame_err_r, parity_err_r, overrun_r, busy_r;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd};
    end
  end

  assign rxs_s = sync_r[1];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr_s),
    .en   (tmr_en_s),
    .half (half_s),
    .full (full_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic and bit-timer control
  always_comb begin
    state_n   = state_r;
    tmr_clr_s = 1'b0;
    tmr_en_s  = (state_r != IDLE) && (state_r != DONE);
    case (state_r)
      IDLE: begin
        tmr_clr_s = 1'b1;
        if (!rxs_s) begin
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (half_s) begin
          tmr_clr_s = 1'b1;
          // A start bit that has gone high again by mid-bit is a glitch
          if (rxs_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
          end
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (full_s && (bit_cnt_r == DATA_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          state_n = DATA;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (full_s) begin
          state_n = STOP;
        end else begin
          state_n = PARITY;
        end
`else
        state_n = IDLE;
`endif
      end
      STOP: begin
        if (full_s && (bit_cnt_r == STOP_LAST)) begin
          state_n = DONE;
        end else begin
          state_n = STOP;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Zero-extend the received bits into the 8-bit output word
  always_comb begin
    word_s                  = 8'd0;
    word_s[DATA_BITS-1:0]   = shift_r;
  end

  // Shift register, bit index and sticky frame/parity flags of the frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r    <= '0;
      bit_cnt_r  <= 3'd0;
      frm_flag_r <= 1'b0;
      par_flag_r <= 1'b0;
    end else begin
      case (state_r)
        START: begin
          bit_cnt_r  <= 3'd0;
          frm_flag_r <= 1'b0;
          par_flag_r <= 1'b0;
        end
        DATA: begin
          if (full_s) begin
            shift_r   <= {rxs_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= (bit_cnt_r == DATA_LAST) ? 3'd0 : bit_cnt_r + 3'd1;
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (full_s) begin
            par_flag_r <= rxs_s ^ parity_bit(word_s, PARITY_ODD != 32'd0);
          end
`endif
        end
        STOP: begin
          if (full_s) begin
            if (!rxs_s) begin
              frm_flag_r <= 1'b1;
            end
            bit_cnt_r <= (bit_cnt_r == STOP_LAST) ? 3'd0 : bit_cnt_r + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output registers: deliver or flag overrun in DONE, drop valid after a handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r       <= 8'd0;
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= (state_n != IDLE);
      if (state_r == DONE) begin
        frame_err_r  <= frm_flag_r;
        parity_err_r <= par_flag_r;
        // A handshake in the same cycle frees the slot, so no overrun
        if (!valid_r || ready) begin
          data_r  <= word_s;
          valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign data       = data_r;
  assign valid      = valid_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule
